id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the MIPS core, directly downstream of the decode control unit.
//  Latches the control buses and decode data for the EX stage.
//  Detects load-use hazards and stalls PC and IF/ID, injecting one bubble per stall.
//  Honours flush requests from branch/jump resolution.
//  Keeps a saturating bubble counter that the debug unit reads.
// PARAMETERS
//  DATA_W      32  width of register-file operands and sign-extended immediate
//  PC_W        32  width of PC+4 carried to EX
//  REG_ADDR_W  5   register address width
//  CNT_W       16  width of the bubble counter
// PORTS
//  clk              in   1           rising-edge clock
//  reset            in   1           reset, synchronous, active-high
//  enable           in   1           global pipeline enable from debug unit; 0 = hold all state
//  flush            in   1           branch/jump taken; squash instruction entering EX
//  in_execute_bus   in   9           {RegDst,ALUSrc1,ALUSrc2,jump,jr,ALUCode[3:0]}
//  in_memory_bus    in   3           {Branch,MemRead,MemWrite}
//  in_wb_bus        in   2           {RegWrite,MemtoReg}
//  in_pc            in   PC_W        PC+4 of the ID instruction
//  in_rs_data       in   DATA_W      register-file read port A
//  in_rt_data       in   DATA_W      register-file read port B
//  in_imm           in   DATA_W      sign-extended immediate
//  in_rs,in_rt,in_rd in  REG_ADDR_W  register fields of the ID instruction
//  in_shamt         in   5           shift amount field
//  out_execute_bus  out  9           registered control for EX
//  out_memory_bus   out  3           registered control for MEM (forwarded by EX/MEM)
//  out_wb_bus       out  2           registered control for WB
//  out_pc,out_rs_data,out_rt_data,out_imm,out_rs,out_rt,out_rd,out_shamt  out  same widths  registered data
//  stall            out  1           combinational; 1 = PC and IF/ID must hold this cycle
//  bubble_count     out  CNT_W       number of bubbles injected, saturating
// BEHAVIOUR
//  - Reset: all out_* registers = 0, bubble_count = 0, stall = 0. Reset overrides enable.
//  - hazard = out_memory_bus[1] & (out_rt != 0) & ((out_rt == in_rs) | (out_rt == in_rt)).
//    Compare in_rt even when the instruction does not read rt; this is conservative and intentional.
//  - stall = hazard & ~flush & enable & ~reset. Purely combinational, same cycle as the hazard.
//  - Per-edge priority:
//    1. reset:  clear everything.
//    2. !enable:  hold every register, including bubble_count.
//    3. flush | hazard:  bubble.
//       - out_execute_bus, out_memory_bus and out_wb_bus are set to 0.
//       - Data registers load the inputs; their value is don't-care but must not be X.
//       - bubble_count increments by 1, saturating at 2^CNT_W-1.
//    4. Otherwise:  load all inputs.
//  - Any X/Z bits on in_*_bus during a bubble must not reach the outputs. Bubble control is forced to 0.
//  - Latency: exactly 1 cycle from in_* to out_*.
//  - Load-use costs exactly one bubble. After the bubble, out_memory_bus[1] = 0, so the hazard self-clears.
//  - Simultaneous flush and hazard: a single bubble, stall = 0 (the ID instruction is being discarded anyway),
//    and bubble_count increments by 1, not 2.
//  - A hazard while enable = 0 gives stall = 0 and no state change. It re-evaluates when enable returns to 1.
//  - Reset asserted mid-stall: outputs clear on that edge, and stall drops combinationally while reset = 1.
// TESTING
//  1. Reset, then enable = 1 with in_execute_bus = 9'h10A, in_rs_data = 32'hDEADBEEF.
//     -> next edge out_execute_bus = 9'h10A, out_rs_data = 32'hDEADBEEF, stall = 0.
//  2. LW $t0 in EX (out_memory_bus = 3'b010, out_rt = 8), ID instruction has in_rs = 8.
//     -> stall = 1 that cycle; next edge control buses = 0 and bubble_count = 1.
//     -> the following cycle stall = 0 and the held instruction loads.
//  3. Same load with in_rt = 0 and out_rt = 0 -> no stall, no bubble.
//  4. flush = 1 together with a load-use hazard -> stall = 0, one bubble, bubble_count += 1.
//  5. enable = 0 for 3 cycles with changing inputs and a pending hazard
//     -> all outputs and bubble_count are unchanged and stall = 0. Re-enable -> stall = 1.
//  6. With CNT_W = 2, force 5 bubbles -> bubble_count sticks at 3.
//     Then assert reset mid-stall -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              0 holds every register (debug freeze)
//   flush               branch/jump taken, squash the instruction entering EX
//   in_*_bus            decode control {exec 9b, mem 3b, wb 2b}
//   in_pc .. in_shamt   decode data and register fields
//   out_*               registered copies for the EX stage
//   stall               combinational, holds PC and IF/ID this cycle
//   bubble_count        saturating count of injected bubbles
module id_ex_stage #(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  flush,
   input  logic [8:0]            in_execute_bus,
   input  logic [2:0]            in_memory_bus,
   input  logic [1:0]            in_wb_bus,
   input  logic [PC_W-1:0]       in_pc,
   input  logic [DATA_W-1:0]     in_rs_data,
   input  logic [DATA_W-1:0]     in_rt_data,
   input  logic [DATA_W-1:0]     in_imm,
   input  logic [REG_ADDR_W-1:0] in_rs,
   input  logic [REG_ADDR_W-1:0] in_rt,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [4:0]            in_shamt,
   output logic [8:0]            out_execute_bus,
   output logic [2:0]            out_memory_bus,
   output logic [1:0]            out_wb_bus,
   output logic [PC_W-1:0]       out_pc,
   output logic [DATA_W-1:0]     out_rs_data,
   output logic [DATA_W-1:0]     out_rt_data,
   output logic [DATA_W-1:0]     out_imm,
   output logic [REG_ADDR_W-1:0] out_rs,
   output logic [REG_ADDR_W-1:0] out_rt,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [4:0]            out_shamt,
   output logic                  stall,
   output logic [CNT_W-1:0]      bubble_count
);
   logic hazard;
   logic bubble;
   // rt is compared even for instructions that do not read it: conservative by design
   assign hazard = out_memory_bus[1] & (out_rt != '0) & ((out_rt == in_rs) | (out_rt == in_rt));
   // a flushed ID instruction is discarded anyway, so it never needs to be held
   assign stall  = hazard & ~flush & enable & ~reset;
   assign bubble = flush | hazard;
   always_ff @(posedge clk) begin
      if (reset) begin
         out_execute_bus <= '0;
         out_memory_bus  <= '0;
         out_wb_bus      <= '0;
         out_pc          <= '0;
         out_rs_data     <= '0;
         out_rt_data     <= '0;
         out_imm         <= '0;
         out_rs          <= '0;
         out_rt          <= '0;
         out_rd          <= '0;
         out_shamt       <= '0;
         bubble_count    <= '0;
      end else if (enable) begin
         // forcing control to constant 0 also keeps unknown input bits out of a bubble
         out_execute_bus <= bubble ? '0 : in_execute_bus;
         out_memory_bus  <= bubble ? '0 : in_memory_bus;
         out_wb_bus      <= bubble ? '0 : in_wb_bus;
         out_pc          <= in_pc;
         out_rs_data     <= in_rs_data;
         out_rt_data     <= in_rt_data;
         out_imm         <= in_imm;
         out_rs          <= in_rs;
         out_rt          <= in_rt;
         out_rd          <= in_rd;
         out_shamt       <= in_shamt;
         if (bubble && bubble_count != '1) bubble_count <= bubble_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;
   localparam int CNT_W = 2;
   localparam int SAT   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        reset, enable, flush;
      logic [8:0]  ex;
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd, shamt;
   } in_t;

   typedef struct packed {
      logic [8:0]  ex;
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd, shamt;
      int          cnt;
      logic        known;
   } st_t;

   typedef struct packed {
      logic stall;
      st_t  s;
   } rec_t;

   logic clk = 0;
   logic reset = 1, enable = 0, flush = 0;
   logic [8:0] in_execute_bus = '0;
   logic [2:0] in_memory_bus = '0;
   logic [1:0] in_wb_bus = '0;
   logic [31:0] in_pc = '0, in_rs_data = '0, in_rt_data = '0, in_imm = '0;
   logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [8:0] out_execute_bus;
   logic [2:0] out_memory_bus;
   logic [1:0] out_wb_bus;
   logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm;
   logic [4:0] out_rs, out_rt, out_rd, out_shamt;
   logic stall;
   logic [CNT_W-1:0] bubble_count;

   int total = 0, passed = 0;
   rec_t q[$];
   st_t m;

   id_ex_stage #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .in_execute_bus(in_execute_bus), .in_memory_bus(in_memory_bus), .in_wb_bus(in_wb_bus),
      .in_pc(in_pc), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .out_execute_bus(out_execute_bus), .out_memory_bus(out_memory_bus), .out_wb_bus(out_wb_bus),
      .out_pc(out_pc), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
      .stall(stall), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic in_t idle();
      in_t s = '0;
      s.enable = 1;
      return s;
   endfunction

   function automatic in_t rnd();
      in_t s;
      s.reset   = $urandom_range(0, 31) == 0;
      s.enable  = $urandom_range(0, 9) != 0;
      s.flush   = $urandom_range(0, 4) == 0;
      s.ex      = 9'($urandom);
      s.mem     = 3'($urandom);
      s.wb      = 2'($urandom);
      s.pc      = $urandom;
      s.rs_data = $urandom;
      s.rt_data = $urandom;
      s.imm     = $urandom;
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom);
      s.shamt   = 5'($urandom);
      return s;
   endfunction

   // One clock of stimulus: the instruction in EX is a load whose destination matches
   // a source of the ID instruction -> hold ID and send a bubble instead.
   task automatic cyc(input in_t s);
      rec_t r;
      logic use_after_load, squash;
      st_t n;
      @(negedge clk);
      reset = s.reset; enable = s.enable; flush = s.flush;
      in_execute_bus = s.ex; in_memory_bus = s.mem; in_wb_bus = s.wb;
      in_pc = s.pc; in_rs_data = s.rs_data; in_rt_data = s.rt_data; in_imm = s.imm;
      in_rs = s.rs; in_rt = s.rt; in_rd = s.rd; in_shamt = s.shamt;
      use_after_load = m.mem[1] && m.rt != 0 && (m.rt == s.rs || m.rt == s.rt);
      r.stall = use_after_load && !s.flush && s.enable && !s.reset;
      squash = s.flush || use_after_load;
      n = m;
      if (s.reset) begin
         n = '0;
         n.known = 1;
      end else if (s.enable) begin
         n.ex = squash ? 9'd0 : s.ex;
         n.mem = squash ? 3'd0 : s.mem;
         n.wb = squash ? 2'd0 : s.wb;
         n.pc = s.pc; n.rs_data = s.rs_data; n.rt_data = s.rt_data; n.imm = s.imm;
         n.rs = s.rs; n.rt = s.rt; n.rd = s.rd; n.shamt = s.shamt;
         n.cnt = squash ? ((m.cnt < SAT) ? m.cnt + 1 : SAT) : m.cnt;
         n.known = !squash;
      end
      r.s = n;
      q.push_back(r);
      m = n;
   endtask

   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q[0];
            chk("stall", 64'(stall), 64'(e.stall));
            @(posedge clk);
            #1;
            e = q.pop_front();
            chk("out_execute_bus", 64'(out_execute_bus), 64'(e.s.ex));
            chk("out_memory_bus", 64'(out_memory_bus), 64'(e.s.mem));
            chk("out_wb_bus", 64'(out_wb_bus), 64'(e.s.wb));
            chk("bubble_count", 64'(bubble_count), 64'(e.s.cnt));
            if (e.s.known) begin
               chk("out_pc", 64'(out_pc), 64'(e.s.pc));
               chk("out_rs_data", 64'(out_rs_data), 64'(e.s.rs_data));
               chk("out_rt_data", 64'(out_rt_data), 64'(e.s.rt_data));
               chk("out_imm", 64'(out_imm), 64'(e.s.imm));
               chk("out_regs", {44'd0, out_rs, out_rt, out_rd, out_shamt},
                   {44'd0, e.s.rs, e.s.rt, e.s.rd, e.s.shamt});
            end
         end
      end
   end

   initial begin
      in_t s;
      int wait_cycles;
      m = '0;
      m.known = 0;
      s = idle(); s.reset = 1;
      cyc(s); cyc(s);
      // load then dependent instruction, with a new value on the data bus
      s = idle(); s.ex = 9'h10A; s.rs_data = 32'hDEADBEEF;
      cyc(s);
      s = idle(); s.mem = 3'b010; s.rt = 5'd8; s.ex = 9'h055; s.wb = 2'b11;
      cyc(s);
      s = idle(); s.rs = 5'd8; s.ex = 9'h1F3; s.mem = 3'b001; s.wb = 2'b10; s.pc = 32'h104;
      cyc(s); cyc(s);
      // load to $zero never stalls
      s = idle(); s.mem = 3'b010; s.rt = 5'd0;
      cyc(s);
      s = idle(); s.ex = 9'h0AA;
      cyc(s);
      // flush together with a load-use hazard
      s = idle(); s.mem = 3'b010; s.rt = 5'd9;
      cyc(s);
      s = idle(); s.rt = 5'd9; s.flush = 1; s.ex = 9'h111;
      cyc(s);
      // freeze with a pending hazard, then release
      s = idle(); s.mem = 3'b010; s.rt = 5'd7;
      cyc(s);
      for (int i = 0; i < 3; i++) begin
         s = rnd(); s.reset = 0; s.flush = 0; s.enable = 0; s.rs = 5'd7;
         cyc(s);
      end
      s = idle(); s.rs = 5'd7; s.ex = 9'h0F0;
      cyc(s); cyc(s);
      // counter saturation, then reset while a stall is pending
      s = idle(); s.reset = 1;
      cyc(s);
      for (int i = 0; i < 5; i++) begin
         s = idle(); s.flush = 1; s.ex = 9'h1FF; s.mem = 3'b111; s.wb = 2'b11;
         cyc(s);
      end
      s = idle(); s.mem = 3'b010; s.rt = 5'd3;
      cyc(s);
      s = idle(); s.rs = 5'd3; s.reset = 1; s.ex = 9'h123;
      cyc(s);
      for (int i = 0; i < 400; i++) cyc(rnd());
      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 5) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (q.size() > 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
